fifo_level: RTL and testbench
=============================

FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of storage entries (>=2; power of two not required).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-1, almost_full threshold (1..DEPTH).
REQ-004 The block SHALL have parameter AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-1).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port d_in, input, WIDTH, write data.
REQ-008 The block SHALL have port d_in_strobe, input, 1, write request, sampled at posedge clk.
REQ-009 The block SHALL have port q_out_strobe, input, 1, read request (consume head word), sampled at posedge clk.
REQ-010 The block SHALL have port clear_err, input, 1, synchronous clear of sticky error flags.
REQ-011 The block SHALL have port q, output, WIDTH, head word (first-word fall-through).
REQ-012 The block SHALL have port q_ready, output, 1, q holds a valid word.
REQ-013 The block SHALL have port empty, output, 1, count==0.
REQ-014 The block SHALL have port full, output, 1, count==DEPTH.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
REQ-016 The block SHALL have port almost_full, output, 1, count>=AF_LEVEL.
REQ-017 The block SHALL have port almost_empty, output, 1, count<=AE_LEVEL.
REQ-018 The block SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-019 Storage SHALL be a DEPTH-entry circular buffer with read/write pointers wrapping from DEPTH-1 to 0, including non-power-of-two DEPTH.
REQ-020 When not empty, q SHALL combinationally show the oldest stored word and q_ready SHALL be 1; a write becomes visible on q within the cycle following its accepting edge (1-cycle latency).
REQ-021 A write SHALL be accepted when d_in_strobe=1 and (full=0 or a read is accepted in the same cycle); the word is stored at the write pointer.
REQ-022 A read SHALL be accepted when q_out_strobe=1 and empty=0; the read pointer advances.
REQ-023 Simultaneous accepted read and write SHALL leave count unchanged, including when full (head leaves, new word enters at tail).
REQ-024 count SHALL increment on write-only, decrement on read-only, never exceed DEPTH or go below 0; empty, full, almost_full, almost_empty SHALL derive from the registered count.
REQ-025 d_in_strobe=1 while full with no accepted read SHALL drop the word, leave state unchanged, and set overflow.
REQ-026 q_out_strobe=1 while empty with no bypass (REQ-033) SHALL leave state unchanged and set underflow.
REQ-027 overflow/underflow SHALL remain 1 until reset or clear_err; a set condition in the same cycle as clear_err SHALL win.
REQ-028 When empty and not bypassing, q SHALL be all zeros and q_ready 0.

Reset
REQ-029 reset=1 at posedge clk SHALL zero both pointers and count, and clear overflow and underflow, regardless of strobes in that cycle.
REQ-030 After reset: empty=1, full=0, q_ready=0, count=0, almost_empty=1, almost_full=0, q=0.
REQ-031 Reset mid-operation SHALL discard all stored words; strobes in the reset cycle SHALL be ignored.
REQ-032 Storage array contents need not be reset.

Configuration
REQ-033 With macro FIFO_LEVEL_BYPASS_EN defined, when empty=1 and d_in_strobe=1 and q_out_strobe=1, q SHALL combinationally equal d_in and q_ready SHALL be 1; at the edge the word is consumed, nothing stored, count stays 0, no flag set.
REQ-034 Without FIFO_LEVEL_BYPASS_EN, in that case the write SHALL be accepted (count becomes 1), the read ignored and underflow set; no combinational d_in-to-q path SHALL exist.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-035 Reset then idle -> empty=1, full=0, q_ready=0, count=0, almost_empty=1, overflow=underflow=0.
REQ-036 Write 8'h11,22,33,44 on four edges -> full=1, count=4, almost_full=1 from count 3, q=8'h11; fifth write 8'h55 -> overflow=1, count=4; four reads return 11,22,33,44 then empty=1.
REQ-037 Full FIFO (11..44), simultaneous write 8'h66 and read -> count=4, q=8'h22; drain yields 22,33,44,66 (pointer wrap).
REQ-038 Empty, both strobes with d_in=8'hAA -> with FIFO_LEVEL_BYPASS_EN: q=8'hAA, q_ready=1 before edge, count=0 after; without: count=1, q=8'hAA after edge, underflow=1.
REQ-039 Read while empty -> underflow=1, held; clear_err pulse -> underflow=0; clear_err concurrent with new underflow -> underflow=1.
REQ-040 Write 3 words, assert reset -> next cycle count=0, empty=1, q_ready=0, flags cleared.

Source files
------------

// File: rtl/fifo_level.sv
// fifo_level: first-word fall-through FIFO with occupancy count, level flags
// and sticky overflow/underflow. DEPTH need not be a power of two.
// Optional: define FIFO_LEVEL_BYPASS_EN so that a simultaneous write and read
// on an empty FIFO passes d_in straight to q without storing it.
module fifo_level #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       d_in_strobe,
  input  logic                       q_out_strobe,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           q,
  output logic                       q_ready,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             bypass;
  logic             rd_acc;
  logic             wr_acc;
  logic             ovf_set;
  logic             udf_set;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

`ifdef FIFO_LEVEL_BYPASS_EN
  assign bypass = empty & d_in_strobe & q_out_strobe;
`else
  assign bypass = 1'b0;
`endif

  // Accept/error decode; a read frees the slot a same-cycle write needs.
  always_comb begin
    rd_acc  = q_out_strobe & ~empty;
    wr_acc  = d_in_strobe & (~full | rd_acc) & ~bypass;
    ovf_set = d_in_strobe & full & ~rd_acc;
    udf_set = q_out_strobe & empty & ~bypass;
  end

  // Head word fall-through; zeros when nothing valid.
  always_comb begin
    q       = '0;
    q_ready = 1'b0;
    if (bypass) begin
      q       = d_in;
      q_ready = 1'b1;
    end else if (!empty) begin
      q       = mem[rd_ptr];
      q_ready = 1'b1;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[wr_ptr] <= d_in;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      if (wr_acc && !rd_acc)      count_q <= count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_q <= count_q - CW'(1);
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (udf_set)        underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1).
module tb_fifo_level;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_in;
  logic       d_in_strobe;
  logic       q_out_strobe;
  logic       clear_err;
  logic [7:0] q;
  logic       q_ready;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  fifo_level #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .d_in_strobe(d_in_strobe),
    .q_out_strobe(q_out_strobe), .clear_err(clear_err), .q(q),
    .q_ready(q_ready), .empty(empty), .full(full), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic c);
    d_in_strobe  = w;
    q_out_strobe = r;
    d_in         = d;
    clear_err    = c;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_q_ready", q_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_q", q, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);

    // Fill to full, level flags along the way
    drive(1'b1, 1'b0, 8'h11, 1'b0); tick();
    chk("w1_count", count, 1);
    chk("w1_q", q, 8'h11);
    chk("w1_q_ready", q_ready, 1);
    chk("w1_ae", almost_empty, 1);
    drive(1'b1, 1'b0, 8'h22, 1'b0); tick();
    chk("w2_count", count, 2);
    chk("w2_ae", almost_empty, 0);
    chk("w2_af", almost_full, 0);
    drive(1'b1, 1'b0, 8'h33, 1'b0); tick();
    chk("w3_af", almost_full, 1);
    chk("w3_full", full, 0);
    drive(1'b1, 1'b0, 8'h44, 1'b0); tick();
    chk("w4_full", full, 1);
    chk("w4_count", count, 4);
    chk("w4_q", q, 8'h11);

    // Overflow: word dropped
    drive(1'b1, 1'b0, 8'h55, 1'b0); tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_q", q, 8'h11);

    // Drain in order
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rd1_q", q, 8'h11); tick();
    chk("rd2_q", q, 8'h22); tick();
    chk("rd3_q", q, 8'h33); tick();
    chk("rd4_q", q, 8'h44); tick();
    chk("drain_empty", empty, 1);
    chk("drain_q", q, 0);
    chk("drain_udf", underflow, 0);
    chk("drain_ovf_held", overflow, 1);

    drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    chk("clr_ovf", overflow, 0);

    // Full with simultaneous read/write wraps pointers
    drive(1'b1, 1'b0, 8'h11, 1'b0); tick();
    drive(1'b1, 1'b0, 8'h22, 1'b0); tick();
    drive(1'b1, 1'b0, 8'h33, 1'b0); tick();
    drive(1'b1, 1'b0, 8'h44, 1'b0); tick();
    drive(1'b1, 1'b1, 8'h66, 1'b0); tick();
    chk("rw_full_count", count, 4);
    chk("rw_full_q", q, 8'h22);
    chk("rw_full_ovf", overflow, 0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    chk("wrap1_q", q, 8'h22); tick();
    chk("wrap2_q", q, 8'h33); tick();
    chk("wrap3_q", q, 8'h44); tick();
    chk("wrap4_q", q, 8'h66); tick();
    chk("wrap_empty", empty, 1);
    chk("wrap_count", count, 0);

    // Both strobes on empty FIFO
    drive(1'b1, 1'b1, 8'hAA, 1'b0);
    #1;
`ifdef FIFO_LEVEL_BYPASS_EN
    chk("byp_pre_q", q, 8'hAA);
    chk("byp_pre_ready", q_ready, 1);
    tick();
    chk("byp_count", count, 0);
    chk("byp_udf", underflow, 0);
    chk("byp_empty", empty, 1);
`else
    chk("nbyp_pre_q", q, 0);
    chk("nbyp_pre_ready", q_ready, 0);
    tick();
    chk("nbyp_count", count, 1);
    chk("nbyp_q", q, 8'hAA);
    chk("nbyp_udf", underflow, 1);
    drive(1'b0, 1'b1, 8'h00, 1'b1); tick();
    chk("nbyp_rd_count", count, 0);
    chk("nbyp_clr_udf", underflow, 0);
`endif

    // Underflow sticky, clear, and set-wins-over-clear
    drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
    chk("udf_set", underflow, 1);
    chk("udf_count", count, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0); tick();
    chk("udf_held", underflow, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    chk("udf_clr", underflow, 0);
    drive(1'b0, 1'b1, 8'h00, 1'b1); tick();
    chk("udf_set_wins", underflow, 1);

    // Reset mid-operation discards contents, ignores strobes
    drive(1'b1, 1'b0, 8'h01, 1'b0); tick();
    drive(1'b1, 1'b0, 8'h02, 1'b0); tick();
    drive(1'b1, 1'b0, 8'h03, 1'b0); tick();
    chk("pre_rst_count", count, 3);
    drive(1'b1, 1'b0, 8'h04, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ready", q_ready, 0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_udf", underflow, 0);
    chk("mid_rst_ovf", overflow, 0);
    tick();
    chk("post_rst_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
